rcvr_mlane: RTL

- Parametrised successor to the single-lane serial receiver paired with tsmt.
- Deserialises LANES parallel serial data lines that share one frame-sync line.
- Each lane is DATA_W bits, MSB first. Assembled words go into a first-word-fall-through FIFO drained by a valid/ready stream.
- Adds framing-error detection, overflow detection, a saturating drop counter and buffering that the single-lane receiver lacks.

---
 rtl/rcvr_pkg.sv | 32 +++
 rtl/rcvr_fwft_fifo.sv | 69 ++++++
 rtl/rcvr_mlane.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rcvr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rcvr_pkg
//  Purpose  : Shared FSM encoding, clog2 helper and parity-width constant for
//             rcvr_mlane. Optional macro: RCVR_MLANE_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
package rcvr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

`ifdef RCVR_MLANE_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   function automatic int clog2(input int i_val);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < i_val) r = i + 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rcvr_fwft_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rcvr_fwft_fifo
//  Purpose  : First-word-fall-through FIFO with registered head and level.
//  Revision : 1.0 - initial release
// ============================================================================
module rcvr_fwft_fifo
   import rcvr_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_rd,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_vld,
   output logic             o_full,
   output logic [AW:0]      o_level
);

   localparam int c_DEPTH = 2**AW;

   logic [WIDTH-1:0] r_mem [c_DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_dout;
   logic [AW:0]      w_rd_ptr_n;
   logic [AW:0]      w_lvl_n;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;

   assign o_level    = r_wr_ptr - r_rd_ptr;
   assign w_empty    = (o_level == '0);
   assign o_full     = (o_level == (AW+1)'(c_DEPTH));
   assign w_pop      = i_rd & ~w_empty;
   assign w_push     = i_wr & (~o_full | w_pop);
   assign w_rd_ptr_n = r_rd_ptr + {{AW{1'b0}}, w_pop};
   assign w_lvl_n    = (r_wr_ptr + {{AW{1'b0}}, w_push}) - w_rd_ptr_n;
   assign o_vld      = ~w_empty;
   assign o_rdata    = r_dout;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

   // Head register tracks the word that will sit at the read pointer next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_dout   <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, w_push};
         r_rd_ptr <= w_rd_ptr_n;
         if (w_lvl_n == '0)
            r_dout <= '0;
         else if (w_push && (r_wr_ptr[AW-1:0] == w_rd_ptr_n[AW-1:0]))
            r_dout <= i_wdata;
         else
            r_dout <= r_mem[w_rd_ptr_n[AW-1:0]];
      end
   end

endmodule
`default_nettype wire

// File: rtl/rcvr_mlane.sv
`default_nettype none
// ============================================================================
//  Module   : rcvr_mlane
//  Purpose  : Multi-lane frame-synced serial receiver feeding a FWFT FIFO.
//             Optional macro: RCVR_MLANE_PARITY_EN (per-lane even parity bit).
//  Revision : 1.0 - initial release
// ============================================================================
module rcvr_mlane
   import rcvr_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int LANES   = 1,
   parameter int FIFO_AW = 3,
   parameter int CNT_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_fs,
   input  logic [LANES-1:0]        i_d,
   output logic [LANES*DATA_W-1:0] o_data,
   output logic                    o_vld,
   input  logic                    i_rdy,
   output logic                    o_frm_err,
   output logic                    o_ovf,
   output logic                    o_par_err,
   output logic [CNT_W-1:0]        o_drop_cnt,
   output logic [FIFO_AW:0]        o_level
);

   localparam int               c_WL      = DATA_W + PAR_BITS;
   localparam int               c_CW      = clog2(c_WL + 1);
   localparam logic [c_CW-1:0]  c_LAST    = c_CW'(c_WL - 1);
   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   state_t                  r_state;
   state_t                  w_state_n;
   logic [c_CW-1:0]         r_cnt;
   logic [CNT_W-1:0]        r_drop_cnt;
   logic                    r_frm;
   logic                    r_ovf;
   logic                    w_load;
   logic                    w_shift;
   logic                    w_done;
   logic                    w_frm;
   logic                    w_par_bad;
   logic                    w_ovf;
   logic                    w_drop;
   logic                    w_wr_req;
   logic                    w_fifo_full;
   logic [LANES*DATA_W-1:0] w_word;
`ifdef RCVR_MLANE_PARITY_EN
   logic [LANES-1:0]        w_lane_bad;
   logic                    r_par;
`endif

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [c_WL-1:0] r_sh;

      always_ff @(posedge clk) begin
         if (rst)
            r_sh <= '0;
         else if (w_load)
            r_sh <= {{(c_WL-1){1'b0}}, i_d[l]};
         else if (w_shift)
            r_sh <= {r_sh[c_WL-2:0], i_d[l]};
      end

      assign w_word[l*DATA_W +: DATA_W] = r_sh[PAR_BITS +: DATA_W];
`ifdef RCVR_MLANE_PARITY_EN
      // Data plus even-parity bit must XOR to zero.
      assign w_lane_bad[l] = ^r_sh;
`endif
   end

`ifdef RCVR_MLANE_PARITY_EN
   assign w_par_bad = |w_lane_bad;
`else
   assign w_par_bad = 1'b0;
`endif

   always_comb begin
      w_state_n = r_state;
      w_load    = 1'b0;
      w_shift   = 1'b0;
      w_done    = 1'b0;
      w_frm     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_fs) begin
               w_load    = 1'b1;
               w_state_n = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (i_fs) begin
               w_frm  = 1'b1;
               w_load = 1'b1;
            end else begin
               w_shift = 1'b1;
               if (r_cnt == c_LAST) w_state_n = ST_DONE;
            end
         end
         ST_DONE: begin
            w_done = 1'b1;
            if (i_fs) begin
               w_load    = 1'b1;
               w_state_n = ST_SHIFT;
            end else begin
               w_state_n = ST_IDLE;
            end
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   assign w_wr_req = w_done & ~w_par_bad;
   assign w_ovf    = w_wr_req & w_fifo_full & ~(o_vld & i_rdy);
   assign w_drop   = w_ovf | (w_done & w_par_bad);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_frm      <= 1'b0;
         r_ovf      <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_state <= w_state_n;
         if (w_load)
            r_cnt <= c_CW'(1);
         else if (w_shift)
            r_cnt <= r_cnt + c_CW'(1);
         r_frm <= w_frm;
         r_ovf <= w_ovf;
         if (w_drop && (r_drop_cnt != c_CNT_MAX))
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
   end

`ifdef RCVR_MLANE_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) r_par <= 1'b0;
      else     r_par <= w_done & w_par_bad;
   end
   assign o_par_err = r_par;
`else
   assign o_par_err = 1'b0;
`endif

   assign o_frm_err  = r_frm;
   assign o_ovf      = r_ovf;
   assign o_drop_cnt = r_drop_cnt;

   rcvr_fwft_fifo #(
      .WIDTH (LANES*DATA_W),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_wr    (w_wr_req),
      .i_wdata (w_word),
      .i_rd    (i_rdy),
      .o_rdata (o_data),
      .o_vld   (o_vld),
      .o_full  (w_fifo_full),
      .o_level (o_level)
   );

endmodule
`default_nettype wire
